// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter
//   Round-robin scheduler that shares one cordic_core sine/cosine engine
//   between NUM_REQ requesters. It latches the winner's angle, resets and
//   then starts the core, waits for the core's busy pulse, captures sin/cos
//   and returns a one-cycle ack to the winner. If busy never rises, or never
//   falls, within TIMEOUT cycles, the ack is flagged with err.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   req            per-requester request, held until its ack
//   angle_in       packed 10-bit angles, requester i at [10i+9:10i]
//   ack            one-hot completion pulse to the granted requester
//   sin_out        captured sine (s0.9)
//   cos_out        captured cosine (s0.9)
//   err            qualifies ack; 1 = aborted by timeout
//   grant_id       current/last granted requester
//   ctrl_busy      controller not idle
//   core_run       core sw_rst_start (0 = hold core in reset)
//   core_angle     core angle input
//   core_sin       sine result from the core
//   core_cos       cosine result from the core
//   core_busy      busy flag from the core
module cordic_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*10-1:0]   angle_in,
    output logic [NUM_REQ-1:0]      ack,
    output logic signed [9:0]       sin_out,
    output logic signed [9:0]       cos_out,
    output logic                    err,
    output logic [1:0]              grant_id,
    output logic                    ctrl_busy,
    output logic                    core_run,
    output logic [9:0]              core_angle,
    input  logic signed [9:0]       core_sin,
    input  logic signed [9:0]       core_cos,
    input  logic                    core_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rr_last_q, rr_last_d;
    logic [1:0]             grant_q, grant_d;
    logic [9:0]             angle_q, angle_d;
    logic signed [9:0]      sin_q, sin_d;
    logic signed [9:0]      cos_q, cos_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    // Requests and angles padded to the 4-requester maximum so a 2-bit
    // index is always in range regardless of NUM_REQ.
    logic [3:0]             req_pad;
    logic [39:0]            ang_pad;
    logic                   win_found;
    logic [1:0]             win_id;
    logic [3:0]             ack_full;

    assign req_pad = 4'(req);
    assign ang_pad = 40'(angle_in);

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [1:0] idx;
            idx = 2'((int'(rr_last_q) + k) % NUM_REQ);
            if (!win_found && req_pad[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        angle_d   = angle_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d   = win_id;
                    rr_last_d = win_id;
                    angle_d   = ang_pad[win_id*10 +: 10];
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                tmo_d   = '0;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                if (core_busy) begin
                    state_d = S_WAIT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
                tmo_d = tmo_q + 1'b1;
            end
            S_WAIT: begin
                // Capture while core_run is still high so the core has not
                // yet been pushed back into reset.
                if (!core_busy) begin
                    sin_d   = core_sin;
                    cos_d   = core_cos;
                    state_d = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
                tmo_d = tmo_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_last_q <= 2'(NUM_REQ - 1);
            grant_q   <= '0;
            angle_q   <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            angle_q   <= angle_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            tmo_q     <= tmo_d;
        end
    end

    // Outputs decode directly from the state register, so reset forces
    // core_run, ack, err and ctrl_busy low immediately.
    assign ack_full   = (state_q == S_DONE || state_q == S_ERR) ? (4'b0001 << grant_q) : 4'b0000;
    assign ack        = ack_full[NUM_REQ-1:0];
    assign err        = (state_q == S_ERR);
    assign core_run   = (state_q == S_FIRE) || (state_q == S_WAIT);
    assign ctrl_busy  = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign core_angle = angle_q;
    assign sin_out    = sin_q;
    assign cos_out    = cos_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
module tb_cordic_req_arbiter;

    localparam int NUM_REQ = 2;

    typedef struct {
        logic [1:0] id;
        logic [9:0] s;
        logic [9:0] c;
        logic       e;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*10-1:0] angle_in = '0;
    logic [NUM_REQ-1:0]    ack;
    logic signed [9:0]     sin_out, cos_out;
    logic                  err;
    logic [1:0]            grant_id;
    logic                  ctrl_busy, core_run;
    logic [9:0]            core_angle;
    logic signed [9:0]     core_sin, core_cos;
    logic                  core_busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic nobusy = 1'b0;

    // Behavioural core: busy high 10 cycles after core_run rises,
    // sin = angle, cos = ~angle.
    logic       m_busy = 1'b0, m_started = 1'b0;
    logic [3:0] m_cnt = '0;
    assign core_busy = m_busy;
    assign core_sin  = core_angle;
    assign core_cos  = ~core_angle;

    always @(posedge clk) begin
        if (!core_run) begin
            m_busy    <= 1'b0;
            m_started <= 1'b0;
            m_cnt     <= '0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            if (!nobusy) begin
                m_busy <= 1'b1;
                m_cnt  <= 4'd10;
            end
        end else if (m_busy) begin
            if (m_cnt == 4'd1) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1'b1;
        end
    end

    always #5 clk = ~clk;

    cordic_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .req(req), .angle_in(angle_in), .ack(ack),
        .sin_out(sin_out), .cos_out(cos_out), .err(err), .grant_id(grant_id),
        .ctrl_busy(ctrl_busy), .core_run(core_run), .core_angle(core_angle),
        .core_sin(core_sin), .core_cos(core_cos), .core_busy(core_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ack is seen; n counts edges from the call, -1 if expired.
    task automatic wait_ack(input int n0, input int budget, output int n);
        n = n0;
        for (int i = 0; i < budget; i++) begin
            tick();
            n++;
            if (ack != '0) return;
        end
        n = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        nobusy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ack, err, ctrl_busy, core_run} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b err=%b busy=%b run=%b, required all 0", ack, err, ctrl_busy, core_run);
        end
        checks++;
        if (sin_out !== 10'd0 || cos_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_data: sin=%0d cos=%0d, required 0/0", sin_out, cos_out);
        end
        checks++;
        if (grant_id !== 2'd0 || core_angle !== 10'd0) begin
            errors++;
            $display("FAIL reset_grant: grant=%0d angle=%0d, required 0/0", grant_id, core_angle);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int   n;
        exp_t x;
        do_reset();
        angle_in[9:0] = 10'd100;
        req = 2'b01;
        sb.push_back('{id: 2'd0, s: 10'd100, c: ~10'd100, e: 1'b0});
        tick();
        checks++;
        if (core_run !== 1'b0 || ctrl_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_arm: run=%b busy=%b, required 0/1", core_run, ctrl_busy);
        end
        tick();
        checks++;
        if (core_run !== 1'b1) begin
            errors++;
            $display("FAIL single_fire: run=%b, required 1", core_run);
        end
        wait_ack(2, 40, n);
        req = '0;
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required 14", n);
        end
        x = sb.pop_front();
        checks++;
        if (ack !== NUM_REQ'(1 << x.id) || sin_out !== x.s || cos_out !== x.c || err !== x.e) begin
            errors++;
            $display("FAIL single_result: ack=%b sin=%0d cos=%0d err=%b, required ack=%b sin=%0d cos=%0d err=%b",
                     ack, sin_out, cos_out, err, NUM_REQ'(1 << x.id), x.s, x.c, x.e);
        end
        checks++;
        if (cos_out !== 10'd923) begin
            errors++;
            $display("FAIL single_cos: got %0d, required 923", cos_out);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int   n;
        exp_t x;
        do_reset();
        angle_in = {10'd300, 10'd64};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{id: 2'd0, s: 10'd64,  c: ~10'd64,  e: 1'b0});
            else            sb.push_back('{id: 2'd1, s: 10'd300, c: ~10'd300, e: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, 60, n);
            if (k == 3) req = '0;
            checks++;
            if (n !== ((k == 0) ? 14 : 15)) begin
                errors++;
                $display("FAIL simul_gap%0d: got %0d cycles, required %0d", k, n, (k == 0) ? 14 : 15);
            end
            x = sb.pop_front();
            checks++;
            if (ack !== NUM_REQ'(1 << x.id) || sin_out !== x.s || cos_out !== x.c || err !== x.e) begin
                errors++;
                $display("FAIL simul_result%0d: ack=%b sin=%0d cos=%0d err=%b, required ack=%b sin=%0d cos=%0d",
                         k, ack, sin_out, cos_out, err, NUM_REQ'(1 << x.id), x.s, x.c);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int   n;
        exp_t x;
        // Previous capture was angle 300; it must survive the abort.
        nobusy = 1'b1;
        angle_in[9:0] = 10'd5;
        req = 2'b01;
        sb.push_back('{id: 2'd0, s: 10'd300, c: ~10'd300, e: 1'b1});
        wait_ack(0, 60, n);
        req = '0;
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, required 34", n);
        end
        x = sb.pop_front();
        checks++;
        if (ack !== NUM_REQ'(1 << x.id) || sin_out !== x.s || cos_out !== x.c || err !== x.e) begin
            errors++;
            $display("FAIL timeout_result: ack=%b sin=%0d cos=%0d err=%b, required ack=%b sin=%0d cos=%0d err=%b",
                     ack, sin_out, cos_out, err, NUM_REQ'(1 << x.id), x.s, x.c, x.e);
        end
        tick();
        checks++;
        if (ctrl_busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b ack=%b err=%b, required 0/0/0", ctrl_busy, ack, err);
        end
        nobusy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   n;
        exp_t x;
        int   seen;
        angle_in[9:0] = 10'd200;
        req = 2'b01;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (core_run !== 1'b1 || core_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_wait: run=%b core_busy=%b, required 1/1", core_run, core_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (core_run !== 1'b0 || ack !== '0 || ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: run=%b ack=%b busy=%b, required 0/0/0", core_run, ack, ctrl_busy);
        end
        req = '0;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack !== '0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_noack: got %0d ack cycles, required 0", seen);
        end
        angle_in[9:0] = 10'd77;
        req = 2'b01;
        sb.push_back('{id: 2'd0, s: 10'd77, c: ~10'd77, e: 1'b0});
        wait_ack(0, 40, n);
        req = '0;
        x = sb.pop_front();
        checks++;
        if (n !== 14 || ack !== NUM_REQ'(1 << x.id) || sin_out !== x.s || cos_out !== x.c || err !== x.e) begin
            errors++;
            $display("FAIL rstmid_fresh: n=%0d ack=%b sin=%0d cos=%0d err=%b, required n=14 ack=%b sin=%0d cos=%0d err=0",
                     n, ack, sin_out, cos_out, err, NUM_REQ'(1 << x.id), x.s, x.c);
        end
        tick();
    endtask

    task automatic test_angle_change();
        int   n;
        exp_t x;
        angle_in[9:0] = 10'd400;
        req = 2'b01;
        sb.push_back('{id: 2'd0, s: 10'd400, c: ~10'd400, e: 1'b0});
        for (int i = 0; i < 6; i++) tick();
        angle_in[9:0] = 10'd9;
        tick();
        checks++;
        if (core_angle !== 10'd400) begin
            errors++;
            $display("FAIL angle_hold: core_angle=%0d, required 400", core_angle);
        end
        wait_ack(7, 40, n);
        req = '0;
        x = sb.pop_front();
        checks++;
        if (n !== 14 || ack !== NUM_REQ'(1 << x.id) || sin_out !== x.s || cos_out !== x.c || err !== x.e) begin
            errors++;
            $display("FAIL angle_result: n=%0d ack=%b sin=%0d cos=%0d, required n=14 ack=%b sin=%0d cos=%0d",
                     n, ack, sin_out, cos_out, NUM_REQ'(1 << x.id), x.s, x.c);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_angle_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
